// File: rtl/io_scan_pkg.sv
// Shared types and default sizing for the IO scan controller.
package io_scan_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_CLK_DIV = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    CAP,
    PLOAD,
    SHIFT,
    LATCH,
    PUB
  } scan_state_e;

endpackage

// File: rtl/io_scan_controller_if.sv
// Bit-peripheral handshake plus external shift-chain pins of the IO scan controller.
interface io_scan_controller_if #(
  parameter int WIDTH = 16
) ();

  logic             IOSCAN_START;
  logic             IOSCAN_BUSY;
  logic             IOSCAN_DONE;
  logic             IOSCAN_WRITE;
  logic [WIDTH-1:0] IOSCAN_OUTPUT;
  logic             IOSCAN_READ;
  logic [WIDTH-1:0] IOSCAN_INPUT;
  logic             SER_CLK;
  logic             SER_DOUT;
  logic             SER_DIN;
  logic             SER_LOAD_N;
  logic             SER_LATCH;

  modport master (
    input  IOSCAN_START, IOSCAN_OUTPUT, SER_DIN,
    output IOSCAN_BUSY, IOSCAN_DONE, IOSCAN_WRITE, IOSCAN_READ, IOSCAN_INPUT,
           SER_CLK, SER_DOUT, SER_LOAD_N, SER_LATCH
  );

  modport slave (
    output IOSCAN_START, IOSCAN_OUTPUT, SER_DIN,
    input  IOSCAN_BUSY, IOSCAN_DONE, IOSCAN_WRITE, IOSCAN_READ, IOSCAN_INPUT,
           SER_CLK, SER_DOUT, SER_LOAD_N, SER_LATCH
  );

endinterface

// File: rtl/ser_phase_timer.sv
// Half-period timer: counts CLK_DIV enabled cycles and pulses tc on the last one.
module ser_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == 8'(CLK_DIV - 1));

  // Dropping the enable clears the count so every phase starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/io_scan_controller.sv
// Serial IO scan: writes the output image down an external shift chain while
// capturing the input chain, then publishes the assembled input word.
module io_scan_controller
  import io_scan_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input logic CLK,
  input logic RST,
  io_scan_controller_if.master bus
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  scan_state_e      state_q, state_d;
  logic             phase_q, phase_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0] out_sr_q, out_sr_d;
  logic [WIDTH-1:0] in_sr_q, in_sr_d;
  logic [WIDTH-1:0] input_q, input_d;
  logic             timer_en;
  logic             tc;

  assign timer_en = (state_q == PLOAD) || (state_q == SHIFT) || (state_q == LATCH);

  ser_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk(CLK),
    .rst(RST),
    .en (timer_en),
    .tc (tc)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    out_sr_d = out_sr_q;
    in_sr_d  = in_sr_q;
    input_d  = input_q;
    case (state_q)
      IDLE: if (bus.IOSCAN_START) state_d = WR;
      WR:   state_d = CAP;
      CAP: begin
        out_sr_d = bus.IOSCAN_OUTPUT;
        bit_d    = '0;
        phase_d  = 1'b0;
        state_d  = PLOAD;
      end
      PLOAD: if (tc) state_d = SHIFT;
      SHIFT: begin
        // Low phase ends by sampling the chain; high phase ends by advancing the output bit.
        if (tc && !phase_q) begin
          in_sr_d = (in_sr_q << 1) | WIDTH'(bus.SER_DIN);
          phase_d = 1'b1;
        end else if (tc) begin
          out_sr_d = out_sr_q << 1;
          phase_d  = 1'b0;
          if (bit_q == BCW'(WIDTH - 1)) begin
            state_d = LATCH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      LATCH: begin
        if (tc) begin
          input_d = in_sr_q;
          state_d = PUB;
        end
      end
      PUB:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      out_sr_q <= '0;
      in_sr_q  <= '0;
      input_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      out_sr_q <= out_sr_d;
      in_sr_q  <= in_sr_d;
      input_q  <= input_d;
    end
  end

  assign bus.IOSCAN_BUSY  = (state_q != IDLE);
  assign bus.IOSCAN_DONE  = (state_q == PUB);
  assign bus.IOSCAN_READ  = (state_q == PUB);
  assign bus.IOSCAN_WRITE = (state_q == WR);
  assign bus.IOSCAN_INPUT = input_q;
  assign bus.SER_CLK      = (state_q == SHIFT) && phase_q;
  assign bus.SER_DOUT     = out_sr_q[WIDTH-1];
  assign bus.SER_LOAD_N   = (state_q != PLOAD);
  assign bus.SER_LATCH    = (state_q == LATCH);

endmodule

// File: tb/tb_io_scan_controller.sv
// Directed bench for io_scan_controller: default 16-bit/div-2 instance plus an 8-bit/div-1 instance.
module tb_io_scan_controller;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  io_scan_controller_if #(.WIDTH(16)) sif ();
  io_scan_controller_if #(.WIDTH(8))  sif8 ();

  io_scan_controller #(.WIDTH(16), .CLK_DIV(2)) dut (.CLK(clk), .RST(rst), .bus(sif));
  io_scan_controller #(.WIDTH(8),  .CLK_DIV(1)) dut8 (.CLK(clk), .RST(rst), .bus(sif8));

  // External chain models: parallel load while SER_LOAD_N is low, shift on SER_CLK rise.
  logic [15:0] chain16 = '0, chain_val16 = '0;
  logic [7:0]  chain8 = '0, chain_val8 = '0;
  logic        prev16 = 1'b0, prev8 = 1'b0;

  assign sif.SER_DIN  = chain16[15];
  assign sif8.SER_DIN = chain8[7];

  always @(posedge clk) begin
    prev16 <= sif.SER_CLK;
    prev8  <= sif8.SER_CLK;
    if (!sif.SER_LOAD_N) chain16 <= chain_val16;
    else if (sif.SER_CLK && !prev16) chain16 <= chain16 << 1;
    if (!sif8.SER_LOAD_N) chain8 <= chain_val8;
    else if (sif8.SER_CLK && !prev8) chain8 <= chain8 << 1;
  end

  // Observation of the 16-bit instance, sampled mid-cycle.
  logic [15:0] dout_word = '0;
  logic [15:0] read_word = '0;
  logic        read_with_done = 1'b0;
  logic        mon_prev = 1'b0;
  int write_cnt = 0, read_cnt = 0, done_cnt = 0, latch_cnt = 0, rise_cnt = 0;
  int write_cyc = 0, read_cyc = 0, lat = 0, gap = 0;

  always @(negedge clk) begin
    mon_prev <= sif.SER_CLK;
    if (sif.SER_CLK && !mon_prev) begin
      dout_word <= {dout_word[14:0], sif.SER_DOUT};
      rise_cnt  <= rise_cnt + 1;
    end
    if (sif.IOSCAN_WRITE) begin
      write_cnt <= write_cnt + 1;
      write_cyc <= cyc;
      gap       <= cyc - read_cyc;
    end
    if (sif.IOSCAN_READ) begin
      read_cnt       <= read_cnt + 1;
      read_cyc       <= cyc;
      lat            <= cyc - write_cyc;
      read_word      <= sif.IOSCAN_INPUT;
      read_with_done <= sif.IOSCAN_DONE;
    end
    if (sif.IOSCAN_DONE) done_cnt <= done_cnt + 1;
    if (sif.SER_LATCH)   latch_cnt <= latch_cnt + 1;
  end

  task automatic wait_reads(input int target, input int budget, output bit ok);
    int n = 0;
    while (read_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    ok = (read_cnt >= target);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    sif.IOSCAN_START = 1'b1;
    @(posedge clk); #1;
    sif.IOSCAN_START = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    ctl = {sif.IOSCAN_BUSY, sif.IOSCAN_DONE, sif.IOSCAN_WRITE, sif.IOSCAN_READ,
           sif.SER_CLK, sif.SER_DOUT, sif.SER_LOAD_N, sif.SER_LATCH};
    total_cnt++;
    if (ctl !== 8'b0000_0010) $display("[TB] FAIL reset_ctl: got %b expected 00000010", ctl);
    else pass_cnt++;
    total_cnt++;
    if (sif.IOSCAN_INPUT !== 16'h0000) $display("[TB] FAIL reset_input: got %h expected 0000", sif.IOSCAN_INPUT);
    else pass_cnt++;
    ctl = {sif8.IOSCAN_BUSY, sif8.IOSCAN_DONE, sif8.IOSCAN_WRITE, sif8.IOSCAN_READ,
           sif8.SER_CLK, sif8.SER_DOUT, sif8.SER_LOAD_N, sif8.SER_LATCH};
    total_cnt++;
    if (ctl !== 8'b0000_0010) $display("[TB] FAIL reset_ctl8: got %b expected 00000010", ctl);
    else pass_cnt++;
  endtask

  task automatic test_scan_data();
    int w0 = write_cnt, r0 = read_cnt, d0 = done_cnt, l0 = latch_cnt;
    bit ok;
    chain_val16 = 16'h3C01;
    sif.IOSCAN_OUTPUT = 16'hA5C3;
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (sif.IOSCAN_BUSY !== 1'b1) $display("[TB] FAIL busy_mid: got %b expected 1", sif.IOSCAN_BUSY);
    else pass_cnt++;
    sif.IOSCAN_START = 1'b1;
    @(posedge clk); #1;
    sif.IOSCAN_START = 1'b0;
    wait_reads(r0 + 1, 200, ok);
    total_cnt++;
    if (!ok) $display("[TB] FAIL scan_timeout: got %0d reads expected %0d", read_cnt - r0, 1);
    else pass_cnt++;
    total_cnt++;
    if (dout_word !== 16'hA5C3) $display("[TB] FAIL dout_bits: got %h expected a5c3", dout_word);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 70) $display("[TB] FAIL latency: got %0d expected 70", lat);
    else pass_cnt++;
    total_cnt++;
    if (latch_cnt - l0 !== 2) $display("[TB] FAIL latch_len: got %0d expected 2", latch_cnt - l0);
    else pass_cnt++;
    total_cnt++;
    if (read_word !== 16'h3C01) $display("[TB] FAIL input_word: got %h expected 3c01", read_word);
    else pass_cnt++;
    total_cnt++;
    if (read_with_done !== 1'b1 || done_cnt - d0 !== 1)
      $display("[TB] FAIL done_with_read: got %b/%0d expected 1/1", read_with_done, done_cnt - d0);
    else pass_cnt++;
    repeat (8) @(posedge clk);
    #1;
    total_cnt++;
    if (write_cnt - w0 !== 1) $display("[TB] FAIL start_ignored: got %0d writes expected 1", write_cnt - w0);
    else pass_cnt++;
    total_cnt++;
    if (sif.IOSCAN_INPUT !== 16'h3C01 || sif.IOSCAN_BUSY !== 1'b0)
      $display("[TB] FAIL input_hold: got %h busy %b expected 3c01 busy 0", sif.IOSCAN_INPUT, sif.IOSCAN_BUSY);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w0 = write_cnt, r0 = read_cnt;
    bit ok;
    chain_val16 = 16'h5AF0;
    sif.IOSCAN_OUTPUT = 16'h0F0F;
    @(posedge clk); #1;
    sif.IOSCAN_START = 1'b1;
    wait_reads(r0 + 3, 400, ok);
    sif.IOSCAN_START = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++;
    if (!ok) $display("[TB] FAIL b2b_timeout: got %0d reads expected 3", read_cnt - r0);
    else pass_cnt++;
    total_cnt++;
    if (write_cnt - w0 !== 3 || read_cnt - r0 !== 3)
      $display("[TB] FAIL b2b_pairs: got %0d/%0d expected 3/3", write_cnt - w0, read_cnt - r0);
    else pass_cnt++;
    total_cnt++;
    if (gap !== 2) $display("[TB] FAIL b2b_gap: got %0d expected 2", gap);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 70) $display("[TB] FAIL b2b_latency: got %0d expected 70", lat);
    else pass_cnt++;
    total_cnt++;
    if (read_word !== 16'h5AF0 || dout_word !== 16'h0F0F)
      $display("[TB] FAIL b2b_data: got %h/%h expected 5af0/0f0f", read_word, dout_word);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    int rise0 = rise_cnt, n = 0;
    int r0, d0, l0;
    bit ok;
    logic [7:0] ctl;
    chain_val16 = 16'h1234;
    sif.IOSCAN_OUTPUT = 16'hFFFF;
    pulse_start();
    while (rise_cnt - rise0 < 7 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    r0 = read_cnt; d0 = done_cnt; l0 = latch_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    ctl = {sif.IOSCAN_BUSY, sif.IOSCAN_DONE, sif.IOSCAN_WRITE, sif.IOSCAN_READ,
           sif.SER_CLK, sif.SER_DOUT, sif.SER_LOAD_N, sif.SER_LATCH};
    total_cnt++;
    if (ctl !== 8'b0000_0010) $display("[TB] FAIL abort_ctl: got %b expected 00000010", ctl);
    else pass_cnt++;
    total_cnt++;
    if (sif.IOSCAN_INPUT !== 16'h0000) $display("[TB] FAIL abort_input: got %h expected 0000", sif.IOSCAN_INPUT);
    else pass_cnt++;
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    total_cnt++;
    if (read_cnt != r0 || done_cnt != d0 || latch_cnt != l0)
      $display("[TB] FAIL abort_pulses: got read %0d done %0d latch %0d expected 0 0 0",
               read_cnt - r0, done_cnt - d0, latch_cnt - l0);
    else pass_cnt++;
    chain_val16 = 16'hBEEF;
    sif.IOSCAN_OUTPUT = 16'h8001;
    pulse_start();
    wait_reads(r0 + 1, 200, ok);
    total_cnt++;
    if (!ok || read_word !== 16'hBEEF || dout_word !== 16'h8001 || lat !== 70)
      $display("[TB] FAIL after_abort: got in %h out %h lat %0d expected beef 8001 70",
               read_word, dout_word, lat);
    else pass_cnt++;
  endtask

  task automatic test_small_config();
    int wc = -1, rc = -1;
    logic [7:0] dw = '0, got = '0;
    logic prev = 1'b0, got_done = 1'b0;
    chain_val8 = 8'hC5;
    sif8.IOSCAN_OUTPUT = 8'h96;
    @(posedge clk); #1;
    sif8.IOSCAN_START = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      sif8.IOSCAN_START = 1'b0;
      if (sif8.IOSCAN_WRITE) wc = k;
      if (sif8.SER_CLK && !prev) dw = {dw[6:0], sif8.SER_DOUT};
      prev = sif8.SER_CLK;
      if (sif8.IOSCAN_READ) begin
        rc = k;
        got = sif8.IOSCAN_INPUT;
        got_done = sif8.IOSCAN_DONE;
      end
    end
    total_cnt++;
    if (wc < 0 || rc < 0 || rc - wc != 20)
      $display("[TB] FAIL small_latency: got %0d expected 20", rc - wc);
    else pass_cnt++;
    total_cnt++;
    if (dw !== 8'h96) $display("[TB] FAIL small_dout: got %h expected 96", dw);
    else pass_cnt++;
    total_cnt++;
    if (got !== 8'hC5 || got_done !== 1'b1)
      $display("[TB] FAIL small_input: got %h done %b expected c5 done 1", got, got_done);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    sif.IOSCAN_START   = 1'b0;
    sif.IOSCAN_OUTPUT  = '0;
    sif8.IOSCAN_START  = 1'b0;
    sif8.IOSCAN_OUTPUT = '0;
    test_reset();
    test_scan_data();
    test_back_to_back();
    test_reset_mid_scan();
    test_small_config();
    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
